// File: rtl/fm_env_pkg.sv
// Shared envelope constants, rate-calculator state encoding and helpers.
// Consumed by adsr_rate_calc and rate_div32; MAX/BYPASS/ZERO match ADSRenv.
package fm_env_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned PROD_W = 48;
  localparam int unsigned TIME_W = 16;
  localparam int unsigned LVL_W  = 8;

  localparam logic [WORD_W-1:0] MAX    = 32'h8000_0000;
  localparam logic [WORD_W-1:0] BYPASS = 32'hFFFF_FFFF;
  localparam logic [WORD_W-1:0] ZERO   = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_MUL,
    S_DIV_A,
    S_DIV_D,
    S_DIV_R,
    S_COMMIT
  } rate_state_t;

  // Clamp a 48-bit product to the 32-bit word range.
  function automatic logic [WORD_W-1:0] sat32(input logic [PROD_W-1:0] p);
    return (|p[PROD_W-1:WORD_W]) ? 32'hFFFF_FFFF : p[WORD_W-1:0];
  endfunction

  // Zero time ramps in one Clk; a non-zero time never yields a zero step.
  function automatic logic [WORD_W-1:0] step_fix(input logic [WORD_W-1:0] q,
                                                 input logic             zero_time);
    if (zero_time)      return MAX;
    else if (q == ZERO) return 32'h0000_0001;
    else                return q;
  endfunction

endpackage

// File: rtl/rate_div32.sv
// 32-bit restoring divider, one quotient bit per Clk.
// Ports: Clk/Reset (sync, active-high); load_i captures dividend_i/divisor_i;
// done_c is high in the cycle that performs the 32nd step, and quotient_c then
// carries the final floored quotient (valid for capture on that same edge).
module rate_div32
  import fm_env_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              load_i,
  input  logic [WORD_W-1:0] dividend_i,
  input  logic [WORD_W-1:0] divisor_i,
  output logic              done_c,
  output logic [WORD_W-1:0] quotient_c
);

  logic [WORD_W-1:0] rem_q, dvd_q, dvs_q;
  logic [WORD_W-1:0] rem_d;
  logic [4:0]        cnt_q;
  logic              busy_q;
  logic [WORD_W:0]   partial, diff;
  logic              qbit;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    partial    = {rem_q, dvd_q[WORD_W-1]};
    diff       = partial - {1'b0, dvs_q};
    qbit       = ~diff[WORD_W];
    rem_d      = qbit ? diff[WORD_W-1:0] : partial[WORD_W-1:0];
    quotient_c = {dvd_q[WORD_W-2:0], qbit};
    done_c     = busy_q && (cnt_q == 5'd31);
  end

  // The dividend register shifts left and fills with quotient bits.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rem_q  <= ZERO;
      dvd_q  <= ZERO;
      dvs_q  <= ZERO;
      cnt_q  <= 5'd0;
      busy_q <= 1'b0;
    end else if (load_i) begin
      rem_q  <= ZERO;
      dvd_q  <= dividend_i;
      dvs_q  <= divisor_i;
      cnt_q  <= 5'd0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q  <= rem_d;
      dvd_q  <= quotient_c;
      cnt_q  <= cnt_q + 5'd1;
      if (cnt_q == 5'd31) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/adsr_rate_calc.sv
// Converts per-voice ms times and an 8-bit sustain level into ADSRenv words.
// Ports: Clk, Reset (sync, active-high), Start (1-cycle request, inputs captured
// with it), aTimeMs/dTimeMs/sTimeMs/rTimeMs, sLevelIn, bypass, mute;
// Busy, Done (1-cycle pulse, outputs valid in that cycle), aStep, dStep,
// sLevel, sTime, rStep. Fixed latency: Start at cycle 0 -> Done at cycle 102.
module adsr_rate_calc
  import fm_env_pkg::*;
#(
  parameter int unsigned CLK_PER_MS = 50000
)
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [TIME_W-1:0] aTimeMs,
  input  logic [TIME_W-1:0] dTimeMs,
  input  logic [LVL_W-1:0]  sLevelIn,
  input  logic [TIME_W-1:0] sTimeMs,
  input  logic [TIME_W-1:0] rTimeMs,
  input  logic              bypass,
  input  logic              mute,
  output logic              Busy,
  output logic              Done,
  output logic [WORD_W-1:0] aStep,
  output logic [WORD_W-1:0] dStep,
  output logic [WORD_W-1:0] sLevel,
  output logic [WORD_W-1:0] sTime,
  output logic [WORD_W-1:0] rStep
);

  localparam logic [PROD_W-1:0] CLK_MS_P = PROD_W'(CLK_PER_MS);

  rate_state_t       state_q;
  logic [TIME_W-1:0] a_ms_q, d_ms_q, s_ms_q, r_ms_q;
  logic [LVL_W-1:0]  lvl_q;
  logic              byp_q, mute_q;
  logic              za_q, zd_q, zr_q;
  logic [WORD_W-1:0] div_a_q, div_d_q, div_r_q;
  logic [WORD_W-1:0] slvl_q, stime_q;
  logic [WORD_W-1:0] sh_a_q, sh_d_q;
  logic              load_q;

  logic [WORD_W-1:0] dvd_c, dvs_c;
  logic              div_done_c;
  logic [WORD_W-1:0] div_q_c;

  // Select the divider operands for the ramp currently being computed.
  always_comb begin
    dvd_c = MAX;
    dvs_c = div_a_q;
    case (state_q)
      S_DIV_D: begin
        dvd_c = MAX - slvl_q;
        dvs_c = div_d_q;
      end
      S_DIV_R: begin
        dvd_c = slvl_q;
        dvs_c = div_r_q;
      end
      default: ;
    endcase
  end

  rate_div32 u_div (
    .Clk       (Clk),
    .Reset     (Reset),
    .load_i    (load_q),
    .dividend_i(dvd_c),
    .divisor_i (dvs_c),
    .done_c    (div_done_c),
    .quotient_c(div_q_c)
  );

  // Sequencer; all outputs move together on the edge entering COMMIT.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      aStep   <= ZERO;
      dStep   <= ZERO;
      sLevel  <= ZERO;
      sTime   <= ZERO;
      rStep   <= ZERO;
      load_q  <= 1'b0;
      a_ms_q  <= '0;
      d_ms_q  <= '0;
      s_ms_q  <= '0;
      r_ms_q  <= '0;
      lvl_q   <= '0;
      byp_q   <= 1'b0;
      mute_q  <= 1'b0;
      za_q    <= 1'b0;
      zd_q    <= 1'b0;
      zr_q    <= 1'b0;
      div_a_q <= ZERO;
      div_d_q <= ZERO;
      div_r_q <= ZERO;
      slvl_q  <= ZERO;
      stime_q <= ZERO;
      sh_a_q  <= ZERO;
      sh_d_q  <= ZERO;
    end else begin
      Done   <= 1'b0;
      load_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            a_ms_q  <= aTimeMs;
            d_ms_q  <= dTimeMs;
            s_ms_q  <= sTimeMs;
            r_ms_q  <= rTimeMs;
            lvl_q   <= sLevelIn;
            byp_q   <= bypass;
            mute_q  <= mute;
            Busy    <= 1'b1;
            state_q <= S_LATCH;
          end
        end
        S_LATCH: begin
          za_q    <= (a_ms_q == '0);
          zd_q    <= (d_ms_q == '0);
          zr_q    <= (r_ms_q == '0);
          state_q <= S_MUL;
        end
        S_MUL: begin
          div_a_q <= sat32(PROD_W'(a_ms_q) * CLK_MS_P);
          div_d_q <= sat32(PROD_W'(d_ms_q) * CLK_MS_P);
          div_r_q <= sat32(PROD_W'(r_ms_q) * CLK_MS_P);
          stime_q <= sat32(PROD_W'(s_ms_q) * CLK_MS_P);
          slvl_q  <= {1'b0, lvl_q, 23'b0};
          load_q  <= 1'b1;
          state_q <= S_DIV_A;
        end
        S_DIV_A: begin
          if (div_done_c) begin
            sh_a_q  <= step_fix(div_q_c, za_q);
            load_q  <= 1'b1;
            state_q <= S_DIV_D;
          end
        end
        S_DIV_D: begin
          if (div_done_c) begin
            sh_d_q  <= step_fix(div_q_c, zd_q);
            load_q  <= 1'b1;
            state_q <= S_DIV_R;
          end
        end
        S_DIV_R: begin
          if (div_done_c) begin
            aStep   <= byp_q ? BYPASS : (mute_q ? ZERO : sh_a_q);
            dStep   <= sh_d_q;
            rStep   <= step_fix(div_q_c, zr_q);
            sLevel  <= slvl_q;
            sTime   <= stime_q;
            Done    <= 1'b1;
            Busy    <= 1'b0;
            state_q <= S_COMMIT;
          end
        end
        S_COMMIT: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adsr_rate_calc.sv
// Bench for adsr_rate_calc: fixed vectors, random jobs against an arithmetic
// model, and hand sequences for ignored Start, back-to-back jobs and mid-job reset.
module tb_adsr_rate_calc;

  localparam int LAT   = 102;
  localparam int LIMIT = 250;

  logic        Clk = 1'b0;
  logic        Reset, Start, bypass, mute;
  logic [15:0] aTimeMs, dTimeMs, sTimeMs, rTimeMs;
  logic [7:0]  sLevelIn;
  logic        Busy, Done;
  logic [31:0] aStep, dStep, sLevel, sTime, rStep;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] a, d, s, r;
    logic [7:0]  l;
    logic        byp, mute;
    logic [31:0] ea, ed, el, et, er;
  } vec_t;

  vec_t vecs[7];
  vec_t cur;

  adsr_rate_calc #(.CLK_PER_MS(50000)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .aTimeMs(aTimeMs), .dTimeMs(dTimeMs), .sLevelIn(sLevelIn),
    .sTimeMs(sTimeMs), .rTimeMs(rTimeMs), .bypass(bypass), .mute(mute),
    .Busy(Busy), .Done(Done), .aStep(aStep), .dStep(dStep),
    .sLevel(sLevel), .sTime(sTime), .rStep(rStep)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input vec_t e);
    chk({tag, ".aStep"},  aStep,  e.ea);
    chk({tag, ".dStep"},  dStep,  e.ed);
    chk({tag, ".sLevel"}, sLevel, e.el);
    chk({tag, ".sTime"},  sTime,  e.et);
    chk({tag, ".rStep"},  rStep,  e.er);
  endtask

  // Step = floor(num / (t ms in Clk cycles)), t=0 -> full scale in one Clk, never 0.
  function automatic logic [31:0] m_step(input longint num, input logic [15:0] t);
    longint dv, q;
    if (t == 0) return 32'h8000_0000;
    dv = longint'(t) * 50000;
    if (dv > 64'sd4294967295) dv = 64'sd4294967295;
    q = num / dv;
    if (q == 0) q = 1;
    return 32'(q);
  endfunction

  function automatic vec_t model(input vec_t v);
    vec_t   e;
    longint full, lvl, st;
    e    = v;
    full = 64'sd2147483648;
    lvl  = longint'(v.l) * 8388608;
    st   = longint'(v.s) * 50000;
    e.ea = v.byp ? 32'hFFFF_FFFF : (v.mute ? 32'h0 : m_step(full, v.a));
    e.ed = m_step(full - lvl, v.d);
    e.er = m_step(lvl, v.r);
    e.el = 32'(lvl);
    e.et = (st > 64'sd4294967295) ? 32'hFFFF_FFFF : 32'(st);
    return e;
  endfunction

  function automatic logic [15:0] rnd_time();
    case ($urandom_range(0, 3))
      0:       return 16'd0;
      1:       return 16'($urandom_range(1, 20));
      2:       return 16'($urandom_range(0, 65535));
      default: return 16'd65535;
    endcase
  endfunction

  task automatic apply(input vec_t v);
    aTimeMs = v.a; dTimeMs = v.d; sTimeMs = v.s; rTimeMs = v.r;
    sLevelIn = v.l; bypass = v.byp; mute = v.mute;
  endtask

  // kind 0: plain job; 1: extra Start at poke; 2: Reset pulse at poke.
  task automatic run_job(input string tag, input vec_t v, input int poke,
                         input int kind, output int lat);
    int cyc;
    apply(v);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    cyc = 1;
    chk({tag, ".busy_c1"}, 32'(Busy), 32'd1);
    while (Done !== 1'b1 && cyc < LIMIT) begin
      if (cyc == poke && kind == 1) begin
        apply(vecs[5]);
        Start = 1'b1;
      end
      if (cyc == poke && kind == 2) Reset = 1'b1;
      tick();
      cyc++;
      Start = 1'b0;
      Reset = 1'b0;
      if (cyc == 2) begin
        aTimeMs = 16'($urandom); dTimeMs = 16'($urandom); sTimeMs = 16'($urandom);
        rTimeMs = 16'($urandom); sLevelIn = 8'($urandom);
        bypass = 1'($urandom); mute = 1'($urandom);
      end
      if (cyc == 50) begin
        chk({tag, ".busy_c50"}, 32'(Busy), 32'd1);
        chk({tag, ".hold_aStep_c50"}, aStep, cur.ea);
        chk({tag, ".hold_rStep_c50"}, rStep, cur.er);
      end
      if (kind == 2 && cyc == poke + 1) begin
        chk({tag, ".rst_busy"}, 32'(Busy), 32'd0);
        chk({tag, ".rst_done"}, 32'(Done), 32'd0);
        cur = '{a:0, d:0, s:0, r:0, l:0, byp:0, mute:0, ea:0, ed:0, el:0, et:0, er:0};
        chk_out({tag, ".rst"}, cur);
      end
    end
    lat = cyc;
    if (Done === 1'b1) chk({tag, ".busy_at_done"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    int   lat, quiet;
    vec_t v;

    vecs[0] = '{a:1,     d:10, s:500, r:100, l:128, byp:0, mute:0,
                ea:32'd42949, ed:32'd2147, el:32'h4000_0000, et:32'h017D_7840, er:32'd214};
    vecs[1] = '{a:0,     d:0,  s:500, r:100, l:128, byp:0, mute:0,
                ea:32'h8000_0000, ed:32'h8000_0000, el:32'h4000_0000, et:32'h017D_7840, er:32'd214};
    vecs[2] = '{a:65535, d:10, s:500, r:100, l:128, byp:0, mute:0,
                ea:32'd1, ed:32'd2147, el:32'h4000_0000, et:32'h017D_7840, er:32'd214};
    vecs[3] = '{a:1,     d:10, s:500, r:100, l:0,   byp:0, mute:0,
                ea:32'd42949, ed:32'd4294, el:32'h0, et:32'h017D_7840, er:32'd1};
    vecs[4] = '{a:1,     d:10, s:500, r:100, l:128, byp:1, mute:1,
                ea:32'hFFFF_FFFF, ed:32'd2147, el:32'h4000_0000, et:32'h017D_7840, er:32'd214};
    vecs[5] = '{a:1,     d:10, s:500, r:100, l:128, byp:0, mute:1,
                ea:32'h0, ed:32'd2147, el:32'h4000_0000, et:32'h017D_7840, er:32'd214};
    vecs[6] = '{a:1,     d:10, s:0,   r:0,   l:255, byp:0, mute:0,
                ea:32'd42949, ed:32'd16, el:32'h7F80_0000, et:32'h0, er:32'h8000_0000};

    cur = '{a:0, d:0, s:0, r:0, l:0, byp:0, mute:0, ea:0, ed:0, el:0, et:0, er:0};
    Reset = 1'b1; Start = 1'b0;
    apply(vecs[0]);
    repeat (3) tick();
    chk("reset.busy", 32'(Busy), 32'd0);
    chk("reset.done", 32'(Done), 32'd0);
    chk_out("reset", cur);

    // Start coinciding with Reset is ignored.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    Reset = 1'b0;
    tick();
    chk("start_in_reset.busy", 32'(Busy), 32'd0);

    // Fixed vectors, each started the cycle after the previous Done.
    foreach (vecs[i]) begin
      run_job($sformatf("vec%0d", i), vecs[i], -1, 0, lat);
      chk($sformatf("vec%0d.latency", i), 32'(lat), 32'(LAT));
      chk_out($sformatf("vec%0d", i), vecs[i]);
      cur = vecs[i];
      tick();
    end

    // Randomized jobs against the arithmetic model.
    for (int i = 0; i < 16; i++) begin
      v.a = rnd_time(); v.d = rnd_time(); v.s = rnd_time(); v.r = rnd_time();
      v.l = 8'($urandom);
      v.byp  = ($urandom_range(0, 3) == 0);
      v.mute = ($urandom_range(0, 3) == 0);
      v = model(v);
      run_job($sformatf("rnd%0d", i), v, -1, 0, lat);
      chk($sformatf("rnd%0d.latency", i), 32'(lat), 32'(LAT));
      chk_out($sformatf("rnd%0d", i), v);
      cur = v;
      tick();
    end

    // Start at cycle 50 of a running job is ignored.
    run_job("ign", vecs[0], 50, 1, lat);
    chk("ign.latency", 32'(lat), 32'(LAT));
    chk_out("ign", vecs[0]);
    cur = vecs[0];
    quiet = 0;
    for (int c = 0; c < 120; c++) begin
      tick();
      if (Done === 1'b1 || Busy === 1'b1) quiet++;
    end
    chk("ign.no_second_job", 32'(quiet), 32'd0);

    // Reset at cycle 60 aborts the job with no Done pulse.
    run_job("rst", vecs[6], 60, 2, lat);
    chk("rst.no_done", 32'(lat), 32'(LIMIT));
    chk_out("rst.after", cur);

    // Fresh job after the abort completes normally.
    tick();
    run_job("fresh", vecs[2], -1, 0, lat);
    chk("fresh.latency", 32'(lat), 32'(LAT));
    chk_out("fresh", vecs[2]);
    tick();
    chk("fresh.done_pulse", 32'(Done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
